cvtb_fifo_drain: RTL and testbench

CVTB_FIFO_DRAIN -- requirements
Module: cvtb_fifo_drain

---
 rtl/cvtb_fifo_drain.sv | 187 ++++++++++++++++++
 tb/tb_cvtb_fifo_drain.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvtb_fifo_drain.sv
// Packet drain engine: reads one stored packet (head..tail, wrapping) out of a
// buffer memory with 1-cycle read latency and streams it to a ready-gated sink
// through a 2-entry output buffer.
module cvtb_fifo_drain #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    input  logic [ADDR_W-1:0] tail_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [WORD_W-1:0] mem_dout,
    input  logic              out_rdy,
    output logic              out_wr,
    output logic [63:0]       out_data,
    output logic [7:0]        out_ctrl,
    output logic              first_out,
    output logic              last_out,
    output logic              busy,
    output logic              done
);

    // Packet length needs one more bit than the address: 256 words is legal.
    localparam int unsigned LenW = ADDR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [LenW-1:0]   to_issue_q, to_issue_d;
    logic [LenW-1:0]   to_send_q, to_send_d;
    logic              first_q, first_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [WORD_W-1:0] buf0_q, buf0_d;
    logic [WORD_W-1:0] buf1_q, buf1_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] span;
    logic [LenW-1:0]   pkt_len;
    logic [2:0]        level;

    // Packet length and read/pop strobes, decoded from registered state.
    always_comb begin
        span    = tail_addr - head_addr;
        pkt_len = LenW'(span) + LenW'(1);
        out_wr  = !rst && (state_q == StRun) && (occ_q != 2'd0) && out_rdy;
        // Words held or still in flight once this cycle's pop is taken.
        level   = 3'(occ_q) + 3'(inflight_q) - 3'(out_wr);
        mem_rd_en = !rst && (state_q == StRun) && (to_issue_q != '0) && (level < 3'd2);
        first_out = out_wr && first_q;
        last_out  = out_wr && (to_send_q == LenW'(1));
    end

    // Registered outputs; the buffer head register drives the payload directly.
    always_comb begin
        mem_addr = rd_ptr_q;
        out_data = buf0_q[63:0];
        out_ctrl = buf0_q[71:64];
        busy     = busy_q;
        done     = done_q;
    end

    // FSM next state, pointers, counters and output buffer update.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        tail_d     = tail_q;
        to_issue_d = to_issue_q;
        to_send_d  = to_send_q;
        first_d    = first_q;
        occ_d      = occ_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        inflight_d = mem_rd_en;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    rd_ptr_d   = head_addr;
                    tail_d     = tail_addr;
                    to_issue_d = pkt_len;
                    to_send_d  = pkt_len;
                    first_d    = 1'b1;
                end
            end
            StRun: begin
                if (mem_rd_en) begin
                    rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    to_issue_d = to_issue_q - LenW'(1);
                end
                if (out_wr) begin
                    to_send_d = to_send_q - LenW'(1);
                    first_d   = 1'b0;
                    if (to_send_q == LenW'(1)) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Push is the word returning from last cycle's read; pop is out_wr.
        unique case ({inflight_q, out_wr})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = mem_dout;
                end else begin
                    buf1_d = mem_dout;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                // Leave the head word in place when emptying so outputs hold.
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = mem_dout;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = mem_dout;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StFlush);
    end

    // State register with synchronous reset; clearing inflight drops late read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            tail_q     <= '0;
            to_issue_q <= '0;
            to_send_q  <= '0;
            first_q    <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            tail_q     <= tail_d;
            to_issue_q <= to_issue_d;
            to_send_q  <= to_send_d;
            first_q    <= first_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Latched tail kept for debug visibility of the active packet bounds.
    logic unused_tail;
    assign unused_tail = ^tail_q;

endmodule

// File: tb/tb_cvtb_fifo_drain.sv
// Bench for cvtb_fifo_drain: a count-based model of the drain checks every cycle,
// directed scenarios pin latency, addresses and counts with literal values.
module tb_cvtb_fifo_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  h_addr;
    logic [7:0]  t_addr;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [71:0] mem_dout = '0;
    logic        out_rdy;
    logic        out_wr;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        first_out;
    logic        last_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    // model state (values for the current cycle)
    logic m_active = 1'b0;
    logic m_flush  = 1'b0;
    int   m_len = 0, m_r = 0, m_o = 0, m_rd_prev = 0;
    logic [7:0] m_head = '0;

    // observations of DUT activity (cumulative)
    int wr_total = 0, first_total = 0, last_total = 0, both_total = 0, done_total = 0;
    int last_first_cyc = 0, last_done_cyc = 0, last_acc_cyc = 0;
    logic [7:0] rd_log[$];

    cvtb_fifo_drain #(.ADDR_W(8), .WORD_W(72)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .head_addr (h_addr),
        .tail_addr (t_addr),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_dout  (mem_dout),
        .out_rdy   (out_rdy),
        .out_wr    (out_wr),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .first_out (first_out),
        .last_out  (last_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] mem_word(input logic [7:0] a);
        return {a ^ 8'hC3, {8{a}} ^ 64'h0123_4567_89AB_CDEF};
    endfunction

    // buffer memory: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_dout <= mem_word(mem_addr);
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input logic [7:0] h, input logic [7:0] t);
        start  = 1'b1;
        h_addr = h;
        t_addr = t;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_total;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_total != d0) break;
        end
        chk("done_within_budget", done_total != d0, 1'b1);
    endtask

    task automatic reset_outputs_check();
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_rd_en", mem_rd_en, 1'b0);
        chk("rst_out_wr", out_wr, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_ctrl", out_ctrl, 8'h00);
        chk("rst_first_out", first_out, 1'b0);
        chk("rst_last_out", last_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
    endtask

    task automatic chk_reads(input string name, input int n0, input logic [7:0] exp[4],
                             input int n);
        chk({name, "_count"}, rd_log.size() - n0, n);
        for (int i = 0; i < n; i++) begin
            if (n0 + i < rd_log.size()) chk({name, "_addr"}, rd_log[n0 + i], exp[i]);
        end
    endtask

    // Mid-cycle compare against the model, then advance the model one clock.
    task automatic compare_loop();
        logic e_wr, e_rd;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            e_wr = !rst && m_active && (m_r - m_rd_prev - m_o > 0) && out_rdy;
            e_rd = !rst && m_active && (m_r < m_len) && (m_r - m_o - (e_wr ? 1 : 0) < 2);
            if (chk_en) begin
                chk("busy", busy, m_active || m_flush);
                chk("done", done, m_flush);
                chk("out_wr", out_wr, e_wr);
                chk("mem_rd_en", mem_rd_en, e_rd);
                if (e_rd && mem_rd_en) chk("mem_addr", mem_addr, 8'(m_head + 8'(m_r)));
                if (e_wr && out_wr) begin
                    a = 8'(m_head + 8'(m_o));
                    chk("out_data", out_data, 64'(mem_word(a)));
                    chk("out_ctrl", out_ctrl, mem_word(a) >> 64);
                    chk("first_out", first_out, m_o == 0);
                    chk("last_out", last_out, m_o == m_len - 1);
                end
            end
            // observations
            if (out_wr) wr_total++;
            if (first_out) begin
                first_total++;
                last_first_cyc = cyc;
            end
            if (last_out) last_total++;
            if (first_out && last_out) both_total++;
            if (done) begin
                done_total++;
                last_done_cyc = cyc;
            end
            if (mem_rd_en) rd_log.push_back(mem_addr);
            // model advance
            if (rst) begin
                m_active = 1'b0;
                m_flush  = 1'b0;
                m_r = 0; m_o = 0; m_rd_prev = 0; m_len = 0;
            end else if (m_flush) begin
                m_flush = 1'b0;
            end else if (m_active) begin
                m_r += e_rd ? 1 : 0;
                m_o += e_wr ? 1 : 0;
                m_rd_prev = e_rd ? 1 : 0;
                if (e_wr && m_o == m_len) begin
                    m_active = 1'b0;
                    m_flush  = 1'b1;
                end
            end else if (start) begin
                m_active = 1'b1;
                m_head   = h_addr;
                m_len    = int'(8'(t_addr - h_addr)) + 1;
                m_r = 0; m_o = 0; m_rd_prev = 0;
                last_acc_cyc = cyc;
            end
            cyc++;
        end
    endtask

    initial begin
        logic [7:0] exp_a[4];
        logic [3:0] pat;
        int n0, w0, d0, f0, l0, b0;
        logic reached;

        rst = 1'b1; start = 1'b0; h_addr = '0; t_addr = '0; out_rdy = 1'b1;
        pat = 4'b1001;
        fork
            compare_loop();
        join_none

        tick(3);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        reset_outputs_check();
        tick(1);

        // basic 4-word drain
        n0 = rd_log.size(); w0 = wr_total; f0 = first_total; l0 = last_total;
        start_pkt(8'h10, 8'h13);
        wait_done(40);
        exp_a[0] = 8'h10; exp_a[1] = 8'h11; exp_a[2] = 8'h12; exp_a[3] = 8'h13;
        chk_reads("t1_reads", n0, exp_a, 4);
        chk("t1_first_latency", last_first_cyc - last_acc_cyc, 3);
        chk("t1_done_latency", last_done_cyc - last_acc_cyc, 7);
        chk("t1_wr_count", wr_total - w0, 4);
        chk("t1_first_count", first_total - f0, 1);
        chk("t1_last_count", last_total - l0, 1);
        tick(2);

        // single-word packet
        w0 = wr_total; b0 = both_total; d0 = done_total;
        start_pkt(8'h40, 8'h40);
        wait_done(20);
        chk("t2_wr_count", wr_total - w0, 1);
        chk("t2_first_and_last", both_total - b0, 1);
        chk("t2_done_count", done_total - d0, 1);
        tick(2);

        // address wrap
        n0 = rd_log.size(); w0 = wr_total;
        start_pkt(8'hFE, 8'h01);
        wait_done(40);
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        chk_reads("t3_reads", n0, exp_a, 4);
        chk("t3_wr_count", wr_total - w0, 4);
        tick(2);

        // backpressure 1,0,0,1
        n0 = rd_log.size(); w0 = wr_total; d0 = done_total;
        start_pkt(8'h20, 8'h27);
        for (int i = 0; i < 200; i++) begin
            out_rdy = pat[i % 4];
            tick(1);
            if (done_total != d0) break;
        end
        out_rdy = 1'b1;
        chk("t4_done_count", done_total - d0, 1);
        chk("t4_wr_count", wr_total - w0, 8);
        chk("t4_read_count", rd_log.size() - n0, 8);
        tick(2);

        // reset mid-drain after the 2nd word
        w0 = wr_total;
        reached = 1'b0;
        start_pkt(8'h30, 8'h37);
        for (int i = 0; i < 20; i++) begin
            if (wr_total - w0 >= 2) begin
                reached = 1'b1;
                break;
            end
            tick(1);
        end
        chk("t5_two_words_seen", reached, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        reset_outputs_check();
        d0 = done_total;
        tick(10);
        chk("t5_no_done", done_total - d0, 0);
        chk("t5_idle_busy", busy, 1'b0);
        n0 = rd_log.size(); w0 = wr_total;
        start_pkt(8'h50, 8'h52);
        wait_done(30);
        exp_a[0] = 8'h50; exp_a[1] = 8'h51; exp_a[2] = 8'h52; exp_a[3] = 8'h00;
        chk_reads("t5_restart_reads", n0, exp_a, 3);
        chk("t5_restart_wr_count", wr_total - w0, 3);
        tick(2);

        // start while busy (in RUN and in FLUSH) is ignored
        n0 = rd_log.size(); w0 = wr_total; d0 = done_total;
        start_pkt(8'h80, 8'h87);
        tick(3);
        start_pkt(8'h00, 8'h00);
        tick(6);
        start_pkt(8'h05, 8'h06);
        tick(5);
        chk("t6_wr_count", wr_total - w0, 8);
        chk("t6_read_count", rd_log.size() - n0, 8);
        chk("t6_done_count", done_total - d0, 1);
        chk("t6_idle_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
